uart_rx: RTL and testbench

Serial receiver paired with `uart_tx`. It deserialises the 10-bit frame `uart_tx` emits: start bit 0, 8 data bits LSB first, stop bit 1. Each completed byte is presented on a parallel bus with a one-cycle `valid` strobe, and stop-bit errors are flagged. It sits on the receive side of the serial link, feeding the Nios-facing register/bus logic. With `CLKS_PER_BIT = 1` it loops back directly from `uart_tx.tx`.

---
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, finds the start bit, samples each bit near its
// middle and presents the byte with a one-cycle valid strobe or a frame_err strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state;
    logic        s1;
    logic        rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    // rx is asynchronous to clk; both flops reset to the idle (high) level
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1   <= rx;
            rx_s <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        if (H == 0) begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= START;
                            cnt   <= CW'(1);
                        end
                    end
                end
                START: begin
                    // A start bit that is already gone at mid-bit was only a glitch
                    if (cnt == CNT_HALF) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift[bit_idx] <= rx_s;
                        cnt            <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data  <= shift;
                            valid <= 1'b1;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A break holds the line low; only a return to idle re-arms start detection
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clock per bit, one at 4 clocks per bit.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx1, rx4;
    logic [7:0] data1, data4;
    logic       valid1, valid4;
    logic       ferr1, ferr4;
    logic       busy1, busy4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int both     = 0;

    int         vt1[$];
    logic [7:0] vd1[$];
    int         ft1[$];
    int         vt4[$];
    logic [7:0] vd4[$];
    int         ft4[$];

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .data(data1),
        .valid(valid1), .frame_err(ferr1), .busy(busy1)
    );

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .rx(rx4), .data(data4),
        .valid(valid4), .frame_err(ferr4), .busy(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc equals k during the interval following rising edge k
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid1) begin vt1.push_back(cyc); vd1.push_back(data1); end
        if (ferr1)  ft1.push_back(cyc);
        if (valid4) begin vt4.push_back(cyc); vd4.push_back(data4); end
        if (ferr4)  ft4.push_back(cyc);
        if ((valid1 && ferr1) || (valid4 && ferr4)) both++;
    end

    task automatic clear_q();
        vt1.delete(); vd1.delete(); ft1.delete();
        vt4.delete(); vd4.delete(); ft4.delete();
    endtask

    task automatic drive_bit(input int inst, input int ncyc, input logic val, output int first);
        first = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            if (inst == 1) rx1 = val;
            else           rx4 = val;
            if (k == 0) first = cyc;
        end
    endtask

    task automatic send(input int inst, input logic [7:0] b, input logic stop_bit, output int t);
        int tmp;
        drive_bit(inst, inst, 1'b0, t);
        for (int i = 0; i < 8; i++) drive_bit(inst, inst, b[i], tmp);
        drive_bit(inst, inst, stop_bit, tmp);
    endtask

    task automatic idle(input int inst, input int n);
        int tmp;
        drive_bit(inst, n, 1'b1, tmp);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx1   = 1'b1;
        rx4   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (data1 !== 8'h00) begin failures++; $display("[TB] FAIL reset_data1: got %h expected 00", data1); end
        checks++; if (valid1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid1: got %b expected 0", valid1); end
        checks++; if (ferr1 !== 1'b0)  begin failures++; $display("[TB] FAIL reset_ferr1: got %b expected 0", ferr1); end
        checks++; if (busy1 !== 1'b0)  begin failures++; $display("[TB] FAIL reset_busy1: got %b expected 0", busy1); end
        checks++; if (data4 !== 8'h00) begin failures++; $display("[TB] FAIL reset_data4: got %h expected 00", data4); end
        checks++; if (busy4 !== 1'b0)  begin failures++; $display("[TB] FAIL reset_busy4: got %b expected 0", busy4); end
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1, 4);
    endtask

    task automatic test_single();
        int t;
        clear_q();
        send(1, 8'hA5, 1'b1, t);
        idle(1, 6);
        checks++; if (vt1.size() !== 1) begin failures++; $display("[TB] FAIL single_count: got %0d expected 1", vt1.size()); end
        if (vt1.size() > 0) begin
            checks++; if (vt1[0] !== t + 12) begin failures++; $display("[TB] FAIL single_time: got %0d expected %0d", vt1[0] - t, 12); end
            checks++; if (vd1[0] !== 8'hA5) begin failures++; $display("[TB] FAIL single_data: got %h expected a5", vd1[0]); end
        end
        checks++; if (data1 !== 8'hA5) begin failures++; $display("[TB] FAIL single_hold: got %h expected a5", data1); end
        checks++; if (ft1.size() !== 0) begin failures++; $display("[TB] FAIL single_ferr: got %0d expected 0", ft1.size()); end
    endtask

    task automatic test_back_to_back();
        int t, t2;
        clear_q();
        send(1, 8'h00, 1'b1, t);
        send(1, 8'hFF, 1'b1, t2);
        idle(1, 6);
        checks++; if (vt1.size() !== 2) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 2", vt1.size()); end
        if (vt1.size() >= 2) begin
            checks++; if (vt1[0] !== t + 12) begin failures++; $display("[TB] FAIL b2b_time0: got %0d expected 12", vt1[0] - t); end
            checks++; if (vt1[1] !== t + 22) begin failures++; $display("[TB] FAIL b2b_time1: got %0d expected 22", vt1[1] - t); end
            checks++; if (vd1[0] !== 8'h00) begin failures++; $display("[TB] FAIL b2b_data0: got %h expected 00", vd1[0]); end
            checks++; if (vd1[1] !== 8'hFF) begin failures++; $display("[TB] FAIL b2b_data1: got %h expected ff", vd1[1]); end
        end
        checks++; if (ft1.size() !== 0) begin failures++; $display("[TB] FAIL b2b_ferr: got %0d expected 0", ft1.size()); end
    endtask

    task automatic test_frame_error();
        int t, tmp, fall;
        logic [7:0] b;
        b = 8'h3C;
        clear_q();
        drive_bit(1, 1, 1'b0, t);
        for (int i = 0; i < 8; i++) drive_bit(1, 1, b[i], tmp);
        drive_bit(1, 15, 1'b0, tmp);
        @(negedge clk);
        checks++; if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL ferr_busy_hold: got %b expected 1", busy1); end
        drive_bit(1, 1, 1'b1, tmp);
        fall = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!busy1) begin
                fall = cyc;
                break;
            end
        end
        checks++; if (fall !== t + 27) begin failures++; $display("[TB] FAIL ferr_busy_fall: got %0d expected %0d (-1 means timeout)", (fall < 0) ? -1 : fall - t, 27); end
        checks++; if (ft1.size() !== 1) begin failures++; $display("[TB] FAIL ferr_count: got %0d expected 1", ft1.size()); end
        if (ft1.size() > 0) begin
            checks++; if (ft1[0] !== t + 12) begin failures++; $display("[TB] FAIL ferr_time: got %0d expected 12", ft1[0] - t); end
        end
        checks++; if (vt1.size() !== 0) begin failures++; $display("[TB] FAIL ferr_valid: got %0d expected 0", vt1.size()); end
        checks++; if (data1 !== 8'hFF) begin failures++; $display("[TB] FAIL ferr_data_keep: got %h expected ff", data1); end
        idle(1, 6);
        checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL ferr_no_restart: got %b expected 0", busy1); end
        checks++; if (ft1.size() !== 1) begin failures++; $display("[TB] FAIL ferr_single_pulse: got %0d expected 1", ft1.size()); end
    endtask

    task automatic test_glitch();
        int t, tmp, bc;
        clear_q();
        idle(4, 3);
        drive_bit(4, 1, 1'b0, t);
        drive_bit(4, 1, 1'b1, tmp);
        bc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy4) bc++;
        end
        checks++; if (bc < 1 || bc > 2) begin failures++; $display("[TB] FAIL glitch_busy: got %0d cycles expected 1..2", bc); end
        checks++; if (vt4.size() + ft4.size() !== 0) begin failures++; $display("[TB] FAIL glitch_pulse: got %0d expected 0", vt4.size() + ft4.size()); end
        send(4, 8'h5A, 1'b1, t);
        idle(4, 8);
        checks++; if (vt4.size() !== 1) begin failures++; $display("[TB] FAIL n4_count: got %0d expected 1", vt4.size()); end
        if (vt4.size() > 0) begin
            checks++; if (vt4[0] !== t + 40) begin failures++; $display("[TB] FAIL n4_time: got %0d expected 40", vt4[0] - t); end
            checks++; if (vd4[0] !== 8'h5A) begin failures++; $display("[TB] FAIL n4_data: got %h expected 5a", vd4[0]); end
        end
        checks++; if (ft4.size() !== 0) begin failures++; $display("[TB] FAIL n4_ferr: got %0d expected 0", ft4.size()); end
    endtask

    task automatic test_reset_midframe();
        int t, tmp, t2;
        logic [7:0] b;
        b = 8'hC3;
        clear_q();
        idle(1, 3);
        drive_bit(1, 1, 1'b0, t);
        for (int i = 0; i < 6; i++) drive_bit(1, 1, b[i], tmp);
        @(negedge clk);
        checks++; if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy1); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx1   = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (data1 !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data: got %h expected 00", data1); end
        checks++; if (busy1 !== 1'b0)  begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy1); end
        checks++; if (valid1 !== 1'b0 || ferr1 !== 1'b0) begin failures++; $display("[TB] FAIL midrst_strobes: got %b%b expected 00", valid1, ferr1); end
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1, 5);
        checks++; if (vt1.size() + ft1.size() !== 0) begin failures++; $display("[TB] FAIL midrst_no_pulse: got %0d expected 0", vt1.size() + ft1.size()); end
        send(1, 8'h81, 1'b1, t2);
        idle(1, 6);
        checks++; if (vt1.size() !== 1) begin failures++; $display("[TB] FAIL midrst_next_count: got %0d expected 1", vt1.size()); end
        if (vt1.size() > 0) begin
            checks++; if (vt1[0] !== t2 + 12) begin failures++; $display("[TB] FAIL midrst_next_time: got %0d expected 12", vt1[0] - t2); end
            checks++; if (vd1[0] !== 8'h81) begin failures++; $display("[TB] FAIL midrst_next_data: got %h expected 81", vd1[0]); end
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int t, gap;
        clear_q();
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send(1, b, 1'b1, t);
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(1, gap);
        end
        idle(1, 15);
        checks++; if (vd1.size() !== 256) begin failures++; $display("[TB] FAIL stream_count: got %0d expected 256", vd1.size()); end
        for (int i = 0; i < 256; i++) begin
            if (i < vd1.size()) begin
                checks++; if (vd1[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL stream_byte%0d: got %h expected %h", i, vd1[i], exp_q[i]); end
            end
        end
        checks++; if (ft1.size() !== 0) begin failures++; $display("[TB] FAIL stream_ferr: got %0d expected 0", ft1.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_midframe();
        test_stream();
        checks++; if (both !== 0) begin failures++; $display("[TB] FAIL strobe_exclusive: got %0d overlaps expected 0", both); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
